trace_capture_unit: RTL and testbench

Synthesizable execution-trace recorder that attaches to the Computer's CPU/memory observation points. It samples retired instructions into a circular trace buffer of parametrised depth and width. Capture is controlled by a PC-match or cycle-limit trigger with programmable post-trigger count, and a done flag replaces fixed-cycle bench termination. A simple indexed readout port drains the buffer oldest-first after capture completes.

---
 rtl/trace_capture_unit_pkg.sv | 48 ++++
 rtl/trace_capture_unit_ram.sv | 28 ++
 rtl/trace_capture_unit.sv | 166 ++++++++++++++++
 tb/tb_trace_capture_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_capture_unit_pkg.sv
// Shared types and helpers for the execution-trace capture unit.
// An entry is packed as {pc, instr, mem_we, mem_addr, mem_wdata}, with mem_wdata in the LSBs.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int entry_w(input int aw, input int dw);
    return 2 * aw + 2 * dw + 1;
  endfunction

  function automatic int off_wdata(input int aw, input int dw);
    return 0 * aw + 0 * dw;
  endfunction

  function automatic int off_mem_addr(input int aw, input int dw);
    return 0 * aw + dw;
  endfunction

  function automatic int off_mem_we(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int off_instr(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

  function automatic int off_pc(input int aw, input int dw);
    return aw + 2 * dw + 1;
  endfunction

endpackage

// File: rtl/trace_capture_unit_ram.sv
// Trace storage: DEPTH x WIDTH array, one write port, one registered read port.
// Contents are intentionally not reset.
module trace_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 65,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/trace_capture_unit.sv
// Execution-trace recorder: circular capture of retired instructions with PC or
// cycle-limit trigger, post-trigger count and oldest-first indexed readout.
//   state | meaning
//   IDLE  | nothing captured since reset
//   ARMED | storing samples, waiting for trigger
//   POST  | trigger seen, storing remaining post-trigger samples
//   DONE  | buffer frozen, readout allowed
module trace_capture_unit
  import trace_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 32,
  parameter int CYC_W        = 32,
  parameter bit STOP_ON_FULL = 1'b0,
  localparam int IDX_W       = clog2(DEPTH),
  localparam int ENTRY_W     = entry_w(ADDR_W, DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               sample_en,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [DATA_W-1:0]  instr,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               trig_pc_en,
  input  logic [ADDR_W-1:0]  trig_pc,
  input  logic [CYC_W-1:0]   cyc_limit,
  input  logic [IDX_W:0]     post_count,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic [IDX_W:0]     count,
  output logic               busy,
  output logic               done,
  output logic               triggered,
  output logic               timeout
);

  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0] CNT_FULL = (IDX_W + 1)'(DEPTH);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [IDX_W:0]     count_nxt;
  logic [IDX_W:0]     post_cnt, post_nxt;
  logic [CYC_W-1:0]   cyc_cnt, cyc_nxt;
  logic               trig_nxt, tmo_nxt;
  logic               ram_we;
  logic               pc_hit, cyc_hit;
  logic               rd_fire, rd_zero;
  logic [IDX_W-1:0]   rd_addr;
  logic [ENTRY_W-1:0] wr_entry, ram_q;

  assign wr_entry = {pc, instr, mem_we, mem_addr, mem_wdata};
  assign pc_hit   = trig_pc_en && sample_en && (pc == trig_pc);
  assign cyc_hit  = (cyc_limit != '0) && (cyc_cnt == cyc_limit - CYC_W'(1));

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    cyc_nxt    = cyc_cnt;
    post_nxt   = post_cnt;
    trig_nxt   = triggered;
    tmo_nxt    = timeout;
    ram_we     = 1'b0;
    if (arm) begin
      state_nxt  = ST_ARMED;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
      cyc_nxt    = '0;
      post_nxt   = '0;
      trig_nxt   = 1'b0;
      tmo_nxt    = 1'b0;
    end else begin
      case (state)
        ST_ARMED: begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
          if (pc_hit || cyc_hit) begin
            trig_nxt = 1'b1;
            tmo_nxt  = !pc_hit;
            if (post_count == '0) begin
              state_nxt = ST_DONE;
            end else begin
              // a sample coinciding with the trigger counts as the first post sample
              ram_we    = sample_en;
              post_nxt  = sample_en ? CNT_ONE : '0;
              state_nxt = (sample_en && post_count == CNT_ONE) ? ST_DONE : ST_POST;
            end
          end else begin
            ram_we = sample_en;
          end
        end
        ST_POST: begin
          ram_we = sample_en;
          if (sample_en) begin
            post_nxt = post_cnt + CNT_ONE;
            if (post_nxt == post_count) begin
              state_nxt = ST_DONE;
            end
          end
        end
        default: ;
      endcase
      if (ram_we) begin
        wr_ptr_nxt = wr_ptr + IDX_W'(1);
        if (count != CNT_FULL) begin
          count_nxt = count + CNT_ONE;
        end
        if (STOP_ON_FULL && count_nxt == CNT_FULL) begin
          state_nxt = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      cyc_cnt   <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      timeout   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_zero   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      count     <= count_nxt;
      cyc_cnt   <= cyc_nxt;
      post_cnt  <= post_nxt;
      triggered <= trig_nxt;
      timeout   <= tmo_nxt;
      rd_valid  <= rd_fire;
      rd_zero   <= ({1'b0, rd_idx} >= count);
    end
  end

  // readout index 0 is the oldest entry still held in the buffer
  assign rd_fire  = rd_req && (state == ST_DONE) && !arm;
  assign rd_addr  = wr_ptr - count[IDX_W-1:0] + rd_idx;
  assign rd_entry = (rd_valid && !rd_zero) ? ram_q : '0;
  assign busy     = (state == ST_ARMED) || (state == ST_POST);
  assign done     = (state == ST_DONE);

  trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .re   (rd_fire),
    .raddr(rd_addr),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_trace_capture_unit.sv
// Bench for trace_capture_unit: a circular DEPTH=8 instance checked against a
// sample-list reference model, plus a STOP_ON_FULL DEPTH=4 instance.
module tb_trace_capture_unit;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int EW = 2 * AW + 2 * DW + 1;
  localparam int DA = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sample_en, mem_we, trig_pc_en;
  logic [AW-1:0] pc, mem_addr, trig_pc;
  logic [DW-1:0] instr, mem_wdata;
  logic [CW-1:0] cyc_limit;

  logic          a_arm, a_rd_req, a_rd_valid, a_busy, a_done, a_trig, a_tmo;
  logic [3:0]    a_post, a_count;
  logic [2:0]    a_idx;
  logic [EW-1:0] a_entry;

  logic          b_arm, b_rd_req, b_rd_valid, b_busy, b_done, b_trig, b_tmo;
  logic [2:0]    b_post, b_count;
  logic [1:0]    b_idx;
  logic [EW-1:0] b_entry;

  trace_capture_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DA), .CYC_W(CW), .STOP_ON_FULL(1'b0)) u_a (
    .clk(clk), .rst(rst), .arm(a_arm), .sample_en(sample_en), .pc(pc), .instr(instr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .cyc_limit(cyc_limit), .post_count(a_post), .rd_req(a_rd_req),
    .rd_idx(a_idx), .rd_valid(a_rd_valid), .rd_entry(a_entry), .count(a_count),
    .busy(a_busy), .done(a_done), .triggered(a_trig), .timeout(a_tmo));

  trace_capture_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .CYC_W(CW), .STOP_ON_FULL(1'b1)) u_b (
    .clk(clk), .rst(rst), .arm(b_arm), .sample_en(sample_en), .pc(pc), .instr(instr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .cyc_limit(cyc_limit), .post_count(b_post), .rd_req(b_rd_req),
    .rd_idx(b_idx), .rd_valid(b_rd_valid), .rd_entry(b_entry), .count(b_count),
    .busy(b_busy), .done(b_done), .triggered(b_trig), .timeout(b_tmo));

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] qa[$];
  logic [EW-1:0] qb[$];
  logic [EW-1:0] exp_a, exp_b;

  // reference model of instance A: phase 0 idle, 1 armed, 2 post, 3 done
  int m_phase = 0;
  int m_cyc = 0;
  int m_post = 0;
  bit m_trig = 1'b0;
  bit m_tmo = 1'b0;
  logic [EW-1:0] m_list[$];
  logic [EW-1:0] b_list[$];

  function automatic logic [EW-1:0] cur_entry();
    return {pc, instr, mem_we, mem_addr, mem_wdata};
  endfunction

  function automatic int m_count();
    return (m_list.size() > DA) ? DA : m_list.size();
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit pc_hit, cyc_hit, store;
    store = 1'b0;
    if (rst || a_arm) begin
      m_phase = rst ? 0 : 1;
      m_list.delete();
      m_cyc = 0;
      m_post = 0;
      m_trig = 1'b0;
      m_tmo = 1'b0;
    end else if (m_phase == 1) begin
      pc_hit = trig_pc_en && sample_en && (pc == trig_pc);
      cyc_hit = (cyc_limit != 0) && (m_cyc == int'(cyc_limit) - 1);
      m_cyc++;
      if (pc_hit || cyc_hit) begin
        m_trig = 1'b1;
        m_tmo = !pc_hit;
        if (a_post == 0) m_phase = 3;
        else begin
          store = sample_en;
          m_post = sample_en ? 1 : 0;
          m_phase = (m_post >= int'(a_post)) ? 3 : 2;
        end
      end else store = sample_en;
    end else if (m_phase == 2) begin
      store = sample_en;
      if (sample_en) begin
        m_post++;
        if (m_post >= int'(a_post)) m_phase = 3;
      end
    end
    if (store) m_list.push_back(cur_entry());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(bit en, int p);
    sample_en = en;
    pc = AW'(p);
    instr = DW'($urandom);
    mem_we = 1'($urandom);
    mem_addr = AW'($urandom);
    mem_wdata = DW'($urandom);
  endtask

  task automatic arm_a(bit tpe, int tpc, int cyc, int post);
    trig_pc_en = tpe;
    trig_pc = AW'(tpc);
    cyc_limit = CW'(cyc);
    a_post = 4'(post);
    a_arm = 1'b1;
    sample_en = 1'b0;
    tick();
    a_arm = 1'b0;
  endtask

  task automatic read_a(int idx, output logic [EW-1:0] got);
    bit exp_v;
    int n;
    a_rd_req = 1'b1;
    a_idx = 3'(idx);
    sample_en = 1'b0;
    exp_v = (m_phase == 3) && !a_arm && !rst;
    n = m_count();
    if (exp_v) qa.push_back((idx < n) ? m_list[m_list.size() - n + idx] : '0);
    tick();
    a_rd_req = 1'b0;
    check("a_rd_valid", int'(a_rd_valid), int'(exp_v));
    got = a_entry;
  endtask

  task automatic check_a_status();
    check("a_done", int'(a_done), int'(m_phase == 3));
    check("a_busy", int'(a_busy), int'(m_phase == 1 || m_phase == 2));
    check("a_count", int'(a_count), m_count());
    check("a_triggered", int'(a_trig), int'(m_trig));
    check("a_timeout", int'(a_tmo), int'(m_tmo));
  endtask

  always @(negedge clk) begin
    if (a_rd_valid) begin
      tests++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL a_rd_unexpected: got rd_valid with entry %h, expected no rd_valid", a_entry);
      end else begin
        exp_a = qa.pop_front();
        if (a_entry !== exp_a) begin
          fails++;
          $display("FAIL a_rd_entry: got %h expected %h", a_entry, exp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rd_valid) begin
      tests++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL b_rd_unexpected: got rd_valid with entry %h, expected no rd_valid", b_entry);
      end else begin
        exp_b = qb.pop_front();
        if (b_entry !== exp_b) begin
          fails++;
          $display("FAIL b_rd_entry: got %h expected %h", b_entry, exp_b);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at time limit, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [EW-1:0] got;
    rst = 1'b1; a_arm = 1'b0; b_arm = 1'b0; a_rd_req = 1'b0; b_rd_req = 1'b0;
    a_idx = '0; b_idx = '0; a_post = '0; b_post = '0;
    trig_pc_en = 1'b0; trig_pc = '0; cyc_limit = '0;
    set_sample(1'b0, 0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_a_busy", int'(a_busy), 0);
    check("rst_a_done", int'(a_done), 0);
    check("rst_a_count", int'(a_count), 0);
    check("rst_a_rd_valid", int'(a_rd_valid), 0);
    check("rst_a_entry_nonzero", int'(a_entry != '0), 0);
    check("rst_a_triggered", int'(a_trig), 0);
    check("rst_b_done", int'(b_done), 0);

    // PC trigger on fifth sample, post_count 1
    arm_a(1'b1, 4, 0, 1);
    for (int p = 0; p < 5; p++) begin
      set_sample(1'b1, p);
      tick();
      if (p == 3) check("basic_done_early", int'(a_done), 0);
    end
    set_sample(1'b0, 0);
    check("basic_done", int'(a_done), 1);
    check("basic_count", int'(a_count), 5);
    check_a_status();
    for (int i = 0; i < 6; i++) begin
      read_a(i, got);
      if (i < 5) check("basic_pc", int'(got[EW-1 -: AW]), i);
      else check("basic_oob_entry_nonzero", int'(got != '0), 0);
    end

    // circular wrap, keeps the newest DEPTH samples
    arm_a(1'b1, 15, 0, 5);
    for (int p = 0; p < 20; p++) begin
      set_sample(1'b1, p);
      tick();
      if (p == 18) check("circ_done_early", int'(a_done), 0);
    end
    set_sample(1'b0, 0);
    check("circ_done", int'(a_done), 1);
    check("circ_count", int'(a_count), 8);
    check_a_status();
    for (int i = 0; i < 8; i++) begin
      read_a(i, got);
      check("circ_pc", int'(got[EW-1 -: AW]), 12 + i);
    end

    // cycle-limit trigger, no post samples
    arm_a(1'b0, 0, 40, 0);
    for (int k = 1; k <= 40; k++) begin
      set_sample(1'($urandom_range(0, 1)), $urandom_range(0, 31));
      tick();
      if (k == 39) check("tmo_done_early", int'(a_done), 0);
    end
    set_sample(1'b0, 0);
    check("tmo_done", int'(a_done), 1);
    check("tmo_timeout", int'(a_tmo), 1);
    check("tmo_triggered", int'(a_trig), 1);
    check_a_status();
    for (int i = 0; i < 8; i++) read_a(i, got);

    // STOP_ON_FULL instance: stops after the fourth sample without a trigger
    trig_pc_en = 1'b0;
    cyc_limit = '0;
    b_post = 3'd4;
    b_arm = 1'b1;
    sample_en = 1'b0;
    tick();
    b_arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_sample(1'b1, 100 + k);
      if (k < 4) b_list.push_back(cur_entry());
      tick();
      if (k == 2) check("full_done_early", int'(b_done), 0);
    end
    set_sample(1'b0, 0);
    check("full_done", int'(b_done), 1);
    check("full_count", int'(b_count), 4);
    check("full_triggered", int'(b_trig), 0);
    for (int i = 0; i < 4; i++) begin
      b_rd_req = 1'b1;
      b_idx = 2'(i);
      qb.push_back(b_list[i]);
      tick();
      b_rd_req = 1'b0;
      check("full_rd_valid", int'(b_rd_valid), 1);
      check("full_pc", int'(b_entry[EW-1 -: AW]), 100 + i);
    end

    // PC match and cycle limit on the same edge; readout refused while armed
    arm_a(1'b1, 16'h77, 5, 2);
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) read_a(0, got);
      else begin
        set_sample(1'b0, 0);
        tick();
      end
    end
    set_sample(1'b1, 16'h77);
    tick();
    check("both_triggered", int'(a_trig), 1);
    check("both_timeout", int'(a_tmo), 0);
    check("both_busy", int'(a_busy), 1);
    set_sample(1'b1, 5);
    tick();
    set_sample(1'b0, 0);
    check_a_status();
    a_arm = 1'b1;
    read_a(0, got);
    a_arm = 1'b0;
    check("arm_rd_busy", int'(a_busy), 1);

    // synchronous reset while in POST
    arm_a(1'b1, 3, 0, 6);
    for (int p = 0; p < 6; p++) begin
      set_sample(1'b1, p);
      tick();
    end
    set_sample(1'b0, 0);
    check("post_busy", int'(a_busy), 1);
    rst = 1'b1;
    a_rd_req = 1'b1;
    tick();
    rst = 1'b0;
    a_rd_req = 1'b0;
    check("rstpost_busy", int'(a_busy), 0);
    check("rstpost_done", int'(a_done), 0);
    check("rstpost_count", int'(a_count), 0);
    check("rstpost_rd_valid", int'(a_rd_valid), 0);
    check("rstpost_triggered", int'(a_trig), 0);
    check("rstpost_b_count", int'(b_count), 0);
    check("rstpost_b_done", int'(b_done), 0);

    // randomized captures against the model
    for (int r = 0; r < 40; r++) begin
      arm_a(1'($urandom_range(0, 1)), $urandom_range(0, 15),
            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60), $urandom_range(0, 8));
      for (int c = 0; c < 150 && m_phase != 3; c++) begin
        set_sample(1'($urandom_range(0, 1)), $urandom_range(0, 15));
        tick();
      end
      set_sample(1'b0, 0);
      check_a_status();
      for (int i = 0; i < 8; i++) read_a(i, got);
    end

    tick();
    tick();
    check("a_queue_left", qa.size(), 0);
    check("b_queue_left", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
